// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin arbiter.
package arb_pkg;

  localparam int N_REQ       = 8;
  localparam int IDX_W       = 3;
  localparam int TO_W        = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Decode a requester index into its one-hot vector.
  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// 8-to-3 priority encoder: lowest set bit wins; vld flags any bit set.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan downward so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in[i]) idx = i[IDX_W-1:0];
    end
    vld = |in;
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// 8-requester round-robin arbiter. A grant is held until done or watchdog expiry.
// Optional build macro ARB_LOCK_EN adds a lock input that lets an owner keep the
// grant across a done pulse while it still requests.
module rr_encoder_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [TO_W-1:0]  wdog_q,  wdog_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [N_REQ-1:0] oh_q,    oh_d;
  logic             to_q,    to_d;

  logic [N_REQ-1:0] pri_mask;
  logic [N_REQ-1:0] req_masked;
  logic [IDX_W-1:0] m_idx, u_idx, win_idx;
  logic             m_vld, u_vld;
  logic             lock_hit;

  // Requesters at or above ptr get first pick; the unmasked search covers the wrap.
  assign pri_mask   = {N_REQ{1'b1}} << ptr_q;
  assign req_masked = req & pri_mask;

  prio_enc8 u_enc_masked (
    .in  (req_masked),
    .idx (m_idx),
    .vld (m_vld)
  );

  prio_enc8 u_enc_full (
    .in  (req),
    .idx (u_idx),
    .vld (u_vld)
  );

  assign win_idx = m_vld ? m_idx : u_idx;

`ifdef ARB_LOCK_EN
  assign lock_hit = lock & req[idx_q];
`else
  assign lock_hit = 1'b0;
`endif

  // Next-state logic: winner capture in IDLE, release/re-grant/watchdog in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    to_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (u_vld) begin
          state_d = ST_GRANT;
          idx_d   = win_idx;
          oh_d    = idx2onehot(win_idx);
        end
      end
      ST_GRANT: begin
        wdog_d = wdog_q + TO_W'(1);
        if (done && lock_hit) begin
          // Same owner keeps the grant; ptr stays put, watchdog restarts.
          wdog_d = '0;
        end else if (done || (wdog_q == TO_LAST)) begin
          // done wins over a simultaneous watchdog expiry, so timeout stays low.
          to_d    = ~done;
          state_d = ST_IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          wdog_d  = '0;
          idx_d   = '0;
          oh_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wdog_q  <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      to_q    <= to_d;
    end
  end

  assign gnt_valid  = (state_q == ST_GRANT);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = oh_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter with a scoreboard of expected outputs.
module tb_rr_encoder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;

  typedef struct {
    string      tag;
    logic       v;
    logic [2:0] i;
    logic [7:0] oh;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_encoder_arbiter #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
`ifdef ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},  {31'd0, gnt_valid}, 32'd0);
    chk({tag, ".idx"},    {29'd0, gnt_idx},   32'd0);
    chk({tag, ".onehot"}, {24'd0, gnt_onehot}, 32'd0);
    chk({tag, ".timeout"},{31'd0, timeout},   32'd0);
  endtask

  // Drive one cycle of stimulus, push what the outputs must be after the edge,
  // then pop and compare once the DUT has clocked.
  task automatic cyc(input string tag, input logic [7:0] r, input logic d,
                     input logic v, input logic [2:0] i, input logic to);
    exp_t e;
    exp_t got;
    req    = r;
    done   = d;
    e.tag  = tag;
    e.v    = v;
    e.i    = v ? i : 3'd0;
    e.oh   = v ? (8'd1 << i) : 8'd0;
    e.to   = to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({got.tag, ".valid"},   {31'd0, gnt_valid},  {31'd0, got.v});
    chk({got.tag, ".idx"},     {29'd0, gnt_idx},    {29'd0, got.i});
    chk({got.tag, ".onehot"},  {24'd0, gnt_onehot}, {24'd0, got.oh});
    chk({got.tag, ".timeout"}, {31'd0, timeout},    {31'd0, got.to});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
`ifdef ARB_LOCK_EN
    lock  = 1'b0;
`endif
    // Reset with all requests high: outputs stay zero.
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    cyc("rst_first", 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("rst_rel",   8'h00, 1'b1, 1'b0, 3'd0, 1'b0);     // ptr -> 1

    // Single requester 5, held grant, then done.
    cyc("r5_gnt",  8'h20, 1'b0, 1'b1, 3'd5, 1'b0);
    cyc("r5_hold", 8'h20, 1'b0, 1'b1, 3'd5, 1'b0);
    cyc("r5_rel",  8'h00, 1'b1, 1'b0, 3'd0, 1'b0);        // ptr -> 6
    cyc("r5_idle", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // Move ptr to 0 via requester 7, then full round-robin rotation.
    cyc("r7_gnt", 8'h80, 1'b0, 1'b1, 3'd7, 1'b0);
    cyc("r7_rel", 8'h80, 1'b1, 1'b0, 3'd0, 1'b0);         // ptr -> 0 (wrap)
    for (int k = 0; k < 9; k++) begin
      cyc($sformatf("rr_gnt%0d", k), 8'hFF, 1'b0, 1'b1, 3'(k % 8), 1'b0);
      cyc($sformatf("rr_rel%0d", k), 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    end                                                    // ptr -> 1

    // Watchdog: 16 grant cycles, single timeout pulse, wrap search from ptr 4.
    cyc("to_gnt", 8'h08, 1'b0, 1'b1, 3'd3, 1'b0);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("to_hold%0d", k), 8'h08, 1'b0, 1'b1, 3'd3, 1'b0);
    cyc("to_fire", 8'h08, 1'b0, 1'b0, 3'd0, 1'b1);
    cyc("to_wrap", 8'h09, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("to_rel",  8'h00, 1'b1, 1'b0, 3'd0, 1'b0);        // ptr -> 1

    // done coincident with the last watchdog cycle: no timeout pulse.
    cyc("dt_gnt", 8'h02, 1'b0, 1'b1, 3'd1, 1'b0);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("dt_hold%0d", k), 8'h02, 1'b0, 1'b1, 3'd1, 1'b0);
    cyc("dt_rel",   8'h02, 1'b1, 1'b0, 3'd0, 1'b0);       // ptr -> 2
    cyc("dt_idle0", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);       // done in IDLE ignored
    cyc("dt_idle1", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc("dt_ptr",   8'hFF, 1'b0, 1'b1, 3'd2, 1'b0);
    cyc("dt_ptrr",  8'h00, 1'b1, 1'b0, 3'd0, 1'b0);       // ptr -> 3

    // Grant held while owner drops req and others appear.
    cyc("hd_gnt",  8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
    cyc("hd_drop", 8'h00, 1'b0, 1'b1, 3'd4, 1'b0);
    cyc("hd_chg",  8'h01, 1'b0, 1'b1, 3'd4, 1'b0);
    cyc("hd_rel",  8'h00, 1'b1, 1'b0, 3'd0, 1'b0);        // ptr -> 5

    // Async reset mid-grant of requester 6.
    cyc("ar_gnt", 8'h40, 1'b0, 1'b1, 3'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("ar_async");
    @(posedge clk);
    #1;
    chk_zero("ar_held");
    rst_n = 1'b1;
    cyc("ar_after", 8'h41, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc("ar_rel",   8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

`ifdef ARB_LOCK_EN
    // Lock with req still held: back-to-back re-grant; without req: release.
    cyc("lk_gnt", 8'h04, 1'b0, 1'b1, 3'd2, 1'b0);
    lock = 1'b1;
    cyc("lk_keep", 8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
    cyc("lk_rel",  8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    lock = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
